// File: rtl/fighter_scene.sv
// ---------------------------------------------------------------------------
// fighter_scene
//
// Purpose:
//   A tiny side-view fighting scene for a 96x64 RGB565 OLED panel. A player
//   fighter walks left/right, jumps and punches. A fixed target box stands on
//   the right. All game state advances once per panel frame. The colour of
//   the pixel currently being requested by the OLED driver is produced
//   combinationally.
//
// Configuration:
//   FIGHTER_HEALTHBAR_EN - when defined, punches that land on the target
//   reduce its health. A health bar is drawn along the top of the screen, and
//   ko reports a knocked-out target. When the macro is undefined, health stays
//   full, no bar is drawn and ko is tied low. The fist is drawn in both builds.
//
// Parameters:
//   GROUND_Y    - first ground row on the panel (default 56)
//   STEP_PX     - horizontal pixels moved per frame while walking (default 1)
//
// Ports:
//   clk         - single clock, shared with the OLED driver
//   reset       - asynchronous active-high reset
//   frame_begin - one-clk pulse per panel frame from the OLED driver
//   btnL/btnR   - walk left / right (raw, asynchronous)
//   btnU        - jump (raw, asynchronous)
//   btnC        - punch (raw, asynchronous)
//   pixel_index - pixel being drawn; x = index mod 96, y = index div 96
//   pixel_data  - RGB565 colour for pixel_index, zero latency
//   ko          - high while target health is 0
// ---------------------------------------------------------------------------
module fighter_scene #(
    parameter int GROUND_Y = 56,
    parameter int STEP_PX  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnU,
    input  logic        btnC,
    input  logic [12:0] pixel_index,
    output logic [15:0] pixel_data,
    output logic        ko
);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } jump_state_t;

    localparam logic [7:0] STEP  = 8'(STEP_PX);
    localparam logic [7:0] X_MAX = 8'd69;

    logic [1:0]  sync_l, sync_r, sync_u, sync_c;
    logic        btn_l, btn_r, btn_u, btn_c;
    logic        c_prev;
    logic        c_edge;
    logic        punch_req;
    logic        frame_update;

    logic [6:0]  fighter_x, fighter_x_next;
    logic [7:0]  x_wide, x_inc, x_dec;
    jump_state_t jump_state, jump_state_next;
    logic [4:0]  jump_h, jump_h_next;
    logic [3:0]  punch_cnt;
    logic        punch_load;

    // Two-flop synchronisers for the raw buttons. The frame_begin pulse is
    // also delayed by one clock, so the update cycle is the one after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_l       <= 2'b00;
            sync_r       <= 2'b00;
            sync_u       <= 2'b00;
            sync_c       <= 2'b00;
            c_prev       <= 1'b0;
            frame_update <= 1'b0;
        end else begin
            sync_l       <= {sync_l[0], btnL};
            sync_r       <= {sync_r[0], btnR};
            sync_u       <= {sync_u[0], btnU};
            sync_c       <= {sync_c[0], btnC};
            c_prev       <= sync_c[1];
            frame_update <= frame_begin;
        end
    end

    assign btn_l  = sync_l[1];
    assign btn_r  = sync_r[1];
    assign btn_u  = sync_u[1];
    assign btn_c  = sync_c[1];
    assign c_edge = btn_c & ~c_prev;

    // A punch edge seen anywhere between frame updates is remembered until the
    // next update. It is dropped there whether it starts a punch or not. So an
    // edge during an active punch is ignored, not deferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            punch_req <= 1'b0;
        end else if (frame_update) begin
            punch_req <= 1'b0;
        end else if (c_edge) begin
            punch_req <= 1'b1;
        end
    end

    assign punch_load = frame_update && (punch_cnt == 4'd0) && (punch_req || c_edge);

    // Horizontal movement with clamping to the walkable range 0..69.
    assign x_wide = {1'b0, fighter_x};
    assign x_inc  = x_wide + STEP;
    assign x_dec  = x_wide - STEP;

    always_comb begin
        fighter_x_next = fighter_x;
        if (btn_r && !btn_l) begin
            fighter_x_next = (x_inc > X_MAX) ? X_MAX[6:0] : x_inc[6:0];
        end else if (btn_l && !btn_r) begin
            fighter_x_next = (x_wide < STEP) ? 7'd0 : x_dec[6:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fighter_x <= 7'd8;
        end else if (frame_update) begin
            fighter_x <= fighter_x_next;
        end
    end

    // Jump FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_state <= GROUND;
            jump_h     <= 5'd0;
        end else begin
            jump_state <= jump_state_next;
            jump_h     <= jump_h_next;
        end
    end

    // Jump FSM next state. A takeoff already shows height 2 in its first frame.
    // The apex frame shows 16, and landing shows 0 again.
    always_comb begin
        jump_state_next = jump_state;
        jump_h_next     = jump_h;
        if (frame_update) begin
            case (jump_state)
                GROUND: begin
                    if (btn_u) begin
                        jump_state_next = RISE;
                        jump_h_next     = 5'd2;
                    end
                end
                RISE: begin
                    jump_h_next = jump_h + 5'd2;
                    if (jump_h_next == 5'd16) begin
                        jump_state_next = FALL;
                    end
                end
                FALL: begin
                    jump_h_next = jump_h - 5'd2;
                    if (jump_h_next == 5'd0) begin
                        jump_state_next = GROUND;
                    end
                end
                default: begin
                    jump_state_next = GROUND;
                    jump_h_next     = 5'd0;
                end
            endcase
        end
    end

    // Punch duration counter: the fist stays out for eight frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            punch_cnt <= 4'd0;
        end else if (punch_load) begin
            punch_cnt <= 4'd8;
        end else if (frame_update && (punch_cnt != 4'd0)) begin
            punch_cnt <= punch_cnt - 4'd1;
        end
    end

`ifdef FIGHTER_HEALTHBAR_EN
    logic [4:0] health;
    logic       hit;

    // A hit counts only on the loading frame of a grounded punch thrown from
    // the rightmost position. The values used are the ones from before this
    // frame's update.
    assign hit = punch_load && (fighter_x >= X_MAX[6:0]) && (jump_state == GROUND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            health <= 5'd31;
        end else if (hit && (health != 5'd0)) begin
            health <= health - 5'd1;
        end
    end

    assign ko = (health == 5'd0);
`else
    assign ko = 1'b0;
`endif

    // Pixel renderer: decode x/y from the linear index and pick the colour of
    // the highest-priority object covering that pixel.
    always_comb begin
        int  px;
        int  py;
        int  fx;
        int  top;
        logic in_fighter;
        logic in_fist;
        logic in_target;
        logic in_bar;
        logic in_ground;

        px  = int'(pixel_index % 13'd96);
        py  = int'(pixel_index / 13'd96);
        fx  = int'(fighter_x);
        top = GROUND_Y - 16 - int'(jump_h);

        in_fighter = (px >= fx) && (px <= fx + 7) && (py >= top) && (py <= top + 15);
        in_fist    = (punch_cnt != 4'd0) && (px >= fx + 8) && (px <= fx + 11)
                     && (py >= top + 4) && (py <= top + 5);
        in_target  = (px >= 80) && (px <= 87) && (py >= GROUND_Y - 16) && (py <= GROUND_Y - 1);
`ifdef FIGHTER_HEALTHBAR_EN
        in_bar     = (health != 5'd0) && (py >= 1) && (py <= 2)
                     && (px >= 2) && (px <= 1 + int'(health));
`else
        in_bar     = 1'b0;
`endif
        in_ground  = (py >= GROUND_Y);

        pixel_data = 16'h0000;
        if (pixel_index >= 13'd6144) begin
            pixel_data = 16'h0000;
        end else if (in_fist) begin
            pixel_data = 16'hF800;
        end else if (in_fighter) begin
            pixel_data = 16'h001F;
        end else if (in_target) begin
            pixel_data = 16'h07E0;
        end else if (in_bar) begin
            pixel_data = 16'hFFE0;
        end else if (in_ground) begin
            pixel_data = 16'h7BEF;
        end
    end

endmodule

// File: doc/fighter_scene.md
FIGHTER_SCENE -- requirements
Module: fighter_scene

Interface
REQ-001 The module SHALL have parameter GROUND_Y, default 56, meaning the first ground row on the 96x64 panel.
REQ-002 The module SHALL have parameter STEP_PX, default 1, meaning horizontal pixels moved per frame while walking.
REQ-003 The module SHALL have port clk, input, 1, the single clock, shared with the OLED driver.
REQ-004 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port frame_begin, input, 1, a one-clk pulse from the OLED driver per frame.
REQ-006 The module SHALL have ports btnL, btnR, btnU, btnC, input, 1 each, raw asynchronous buttons.
REQ-007 The module SHALL have port pixel_index, input, 13, from the OLED driver: x = index mod 96, y = index div 96.
REQ-008 The module SHALL have port pixel_data, output, 16, RGB565 colour for pixel_index.
REQ-009 The module SHALL have port ko, output, 1, high while target health is 0.

Function
REQ-010 Each button SHALL pass through a 2-flop synchroniser; game state SHALL update only in the clk cycle after frame_begin is sampled high.
REQ-011 fighter_x (7 bit): btnL only -> minus STEP_PX, clamped at 0; btnR only -> plus STEP_PX, clamped at 69; both or neither -> hold.
REQ-012 Jump FSM states: GROUND, RISE, FALL; jump_h (5 bit) is 0 in GROUND.
REQ-013 GROUND -> RISE when btnU is high at the frame update; btnU while in RISE or FALL SHALL be ignored.
REQ-014 RISE: jump_h += 2 per frame; on reaching 16 -> FALL. FALL: jump_h -= 2 per frame; on reaching 0 -> GROUND.
REQ-015 Fighter box SHALL be 8x16: x in [fighter_x, fighter_x+7], y in [GROUND_Y-16-jump_h, GROUND_Y-1-jump_h].
REQ-016 Punch: a btnC rising edge, between consecutive frame updates, with punch_cnt = 0 SHALL load punch_cnt = 8; punch_cnt SHALL decrement by 1 per frame to 0.
REQ-017 A btnC edge while punch_cnt != 0 SHALL be ignored; holding btnC SHALL start exactly one punch.
REQ-018 Fist box SHALL be shown while punch_cnt != 0 and SHALL span x in [fighter_x+8, fighter_x+11], y in [fighter top+4, fighter top+5].
REQ-019 Target box SHALL be fixed at x 80..87, y GROUND_Y-16..GROUND_Y-1.
REQ-020 A hit SHALL register only in the frame the punch loads, and only if fighter_x >= 69 and jump state is GROUND.
REQ-021 Each hit SHALL decrement target health (5 bit, 0..31) by 1, saturating at 0; ko SHALL equal (health == 0).
REQ-022 pixel_data SHALL be combinational from pixel_index and registered state, with zero cycle latency.
REQ-023 Colour priority SHALL be fist 16'hF800 > fighter 16'h001F > target 16'h07E0 > health bar 16'hFFE0 > ground (y >= GROUND_Y) 16'h7BEF > background 16'h0000.
REQ-024 Health bar SHALL be drawn at rows 1..2, x in [2, 2+health-1]; no bar pixels when health = 0.
REQ-025 pixel_index >= 6144 SHALL output 16'h0000.

Reset
REQ-026 On reset, state SHALL clear asynchronously: fighter_x = 8, jump FSM = GROUND, jump_h = 0, punch_cnt = 0, health = 31, ko = 0, synchroniser and edge-detect flops = 0.
REQ-027 Reset mid-jump or mid-punch SHALL abort immediately to the reset values, with no residual frame update.

Configuration
REQ-028 Macro FIGHTER_HEALTHBAR_EN: when defined, REQ-020/021/024 SHALL apply as written.
REQ-029 When FIGHTER_HEALTHBAR_EN is undefined: no bar SHALL be drawn, health SHALL stay 31, ko SHALL be tied 0, and the fist SHALL still be drawn.

Verification
REQ-030 Reset, no buttons: index 40*96+8 -> 16'h001F; index 56*96+0 -> 16'h7BEF; index 1*96+32 -> 16'hFFE0; ko = 0.
REQ-031 btnR held for 70 frames -> fighter_x = 69 (clamp); btnL+btnR held together -> x unchanged.
REQ-032 btnU pulse -> jump_h sequence 2,4,..,16,14,..,0 over 16 frames; second btnU at frame 3 is ignored.
REQ-033 fighter_x = 69, 31 separate btnC presses, each spaced at least 9 frames apart -> health reaches 0 and ko = 1; a 32nd press keeps health at 0.
REQ-034 btnC held for 20 frames -> exactly one punch; fist at index 44*96+77 is 16'hF800 for 8 frames.
REQ-035 Assert reset mid-jump at jump_h = 10 -> immediate jump_h = 0, fighter_x = 8, GROUND state; repeat REQ-030 checks with the macro undefined -> no bar pixels and ko = 0 after hits.
